// File: rtl/sccb_master_engine_if.sv
// Command, data and pad signals between the register-init sequencer, the SCCB
// master engine and the pad ring.
interface sccb_master_engine_if #(
    parameter int SUB_ADDR_BYTES = 1,
    parameter int LEN_W          = 4
);
    logic                        i_cmd_valid;
    logic                        o_cmd_ready;
    logic                        i_cmd_rw;
    logic [6:0]                  i_dev_addr;
    logic [8*SUB_ADDR_BYTES-1:0] i_sub_addr;
    logic [LEN_W-1:0]            i_len;
    logic [7:0]                  i_wdata;
    logic                        o_wr_req;
    logic [7:0]                  o_rd_data;
    logic                        o_rd_valid;
    logic                        o_sio_c;
    logic                        o_sio_d_out;
    logic                        o_sio_d_oe;
    logic                        i_sio_d;
    logic                        o_sccb_e;
    logic                        o_busy;
    logic                        o_done;
    logic                        o_ack_err;

    modport master (
        input  i_cmd_valid, i_cmd_rw, i_dev_addr, i_sub_addr, i_len, i_wdata, i_sio_d,
        output o_cmd_ready, o_wr_req, o_rd_data, o_rd_valid, o_sio_c, o_sio_d_out,
        output o_sio_d_oe, o_sccb_e, o_busy, o_done, o_ack_err
    );

    modport slave (
        output i_cmd_valid, i_cmd_rw, i_dev_addr, i_sub_addr, i_len, i_wdata, i_sio_d,
        input  o_cmd_ready, o_wr_req, o_rd_data, o_rd_valid, o_sio_c, o_sio_d_out,
        input  o_sio_d_oe, o_sccb_e, o_busy, o_done, o_ack_err
    );
endinterface

// File: rtl/sccb_master_engine.sv
// SCCB master: one command per handshake, 1/2-byte sub-address, write/read bursts.
// Pads are driven as value + output enable; the open-drain buffer lives outside.
//
// state   | meaning
// IDLE    | bus released, ready for a command
// START   | SCCB_E low, SIO_D falls while SIO_C high, then SIO_C falls
// ID_W    | device ID with write bit
// SUB     | sub-address bytes, MSB byte first
// WDATA   | write data bytes from i_wdata
// STOP    | SIO_C rises, SIO_D rises, SCCB_E high; may chain into START for reads
// ID_R    | device ID with read bit
// RDATA   | read data bytes, master drives 9th bit (0 = more, 1 = last)
module sccb_master_engine #(
    parameter int SYS_CLK_FREQ   = 100_000_000,
    parameter int SCCB_CLK_FREQ  = 100_000,
    parameter int SUB_ADDR_BYTES = 1,
    parameter int LEN_W          = 4,
    parameter bit CHECK_ACK      = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    sccb_master_engine_if.master bus
);
    localparam int QDIV_RAW = SYS_CLK_FREQ / (4 * SCCB_CLK_FREQ);
    localparam int QDIV     = (QDIV_RAW < 2) ? 2 : QDIV_RAW;
    localparam int QW       = $clog2(QDIV);
    localparam int SW       = 8 * SUB_ADDR_BYTES;
    localparam logic [QW-1:0] QLOAD = QW'(QDIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ID_W, S_SUB, S_WDATA, S_STOP, S_ID_R, S_RDATA
    } state_t;

    state_t            state, state_nx;
    logic [QW-1:0]     qdiv_cnt;
    logic              tick;
    logic [1:0]        quarter, quarter_nx;
    logic [3:0]        bit_idx, bit_nx;
    logic [7:0]        tx_sh, tx_nx;
    logic [7:0]        rx_sh, rx_nx;
    logic [SW-1:0]     sub_sh, sub_sh_nx;
    logic [1:0]        sub_left, sub_left_nx;
    logic [LEN_W-1:0]  len_left, len_nx;
    logic              rw_q, rw_nx;
    logic [6:0]        dev_q, dev_nx;
    logic              restart, restart_nx;
    logic              err, err_nx;
    logic              nack, nack_nx;
    logic [7:0]        rd_data, rd_data_nx;
    logic              done_q, done_nx;
    logic              wr_req_q, wr_req_nx;
    logic              rd_valid_q, rd_valid_nx;
    logic              sio_d_m, sio_d_s;
    logic              pad_c, pad_d, pad_oe, pad_e;

    assign tick = (qdiv_cnt == '0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= S_IDLE;
            qdiv_cnt   <= '0;
            quarter    <= 2'd0;
            bit_idx    <= 4'd0;
            tx_sh      <= 8'h00;
            rx_sh      <= 8'h00;
            sub_sh     <= '0;
            sub_left   <= 2'd0;
            len_left   <= '0;
            rw_q       <= 1'b0;
            dev_q      <= 7'h00;
            restart    <= 1'b0;
            err        <= 1'b0;
            nack       <= 1'b0;
            rd_data    <= 8'h00;
            done_q     <= 1'b0;
            wr_req_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            sio_d_m    <= 1'b1;
            sio_d_s    <= 1'b1;
        end else begin
            // quarter-bit timer: down-counter reloaded at terminal count
            if (state == S_IDLE || tick) qdiv_cnt <= QLOAD;
            else                         qdiv_cnt <= qdiv_cnt - QW'(1);
            state      <= state_nx;
            quarter    <= quarter_nx;
            bit_idx    <= bit_nx;
            tx_sh      <= tx_nx;
            rx_sh      <= rx_nx;
            sub_sh     <= sub_sh_nx;
            sub_left   <= sub_left_nx;
            len_left   <= len_nx;
            rw_q       <= rw_nx;
            dev_q      <= dev_nx;
            restart    <= restart_nx;
            err        <= err_nx;
            nack       <= nack_nx;
            rd_data    <= rd_data_nx;
            done_q     <= done_nx;
            wr_req_q   <= wr_req_nx;
            rd_valid_q <= rd_valid_nx;
            // SIO_D is asynchronous to clk_sys; two flops settle well inside one quarter
            sio_d_m    <= bus.i_sio_d;
            sio_d_s    <= sio_d_m;
        end
    end

    always_comb begin
        state_nx    = state;
        quarter_nx  = quarter;
        bit_nx      = bit_idx;
        tx_nx       = tx_sh;
        rx_nx       = rx_sh;
        sub_sh_nx   = sub_sh;
        sub_left_nx = sub_left;
        len_nx      = len_left;
        rw_nx       = rw_q;
        dev_nx      = dev_q;
        restart_nx  = restart;
        err_nx      = err;
        nack_nx     = nack;
        rd_data_nx  = rd_data;
        done_nx     = 1'b0;
        wr_req_nx   = 1'b0;
        rd_valid_nx = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.i_cmd_valid) begin
                    state_nx    = S_START;
                    quarter_nx  = 2'd0;
                    rw_nx       = bus.i_cmd_rw;
                    dev_nx      = bus.i_dev_addr;
                    sub_sh_nx   = bus.i_sub_addr;
                    len_nx      = (bus.i_cmd_rw && bus.i_len == '0) ? LEN_W'(1) : bus.i_len;
                    err_nx      = 1'b0;
                    restart_nx  = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    quarter_nx = quarter + 2'd1;
                    if (quarter == 2'd3) begin
                        bit_nx = 4'd0;
                        if (restart) begin
                            state_nx   = S_ID_R;
                            tx_nx      = {dev_q, 1'b1};
                            restart_nx = 1'b0;
                        end else begin
                            state_nx = S_ID_W;
                            tx_nx    = {dev_q, 1'b0};
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    quarter_nx = quarter + 2'd1;
                    if (quarter == 2'd3) begin
                        if (restart) begin
                            state_nx = S_START;
                        end else begin
                            state_nx = S_IDLE;
                            done_nx  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (tick) begin
                    quarter_nx = quarter + 2'd1;
                    if (quarter == 2'd2) begin
                        if (bit_idx == 4'd8) nack_nx = sio_d_s;
                        else                 rx_nx   = {rx_sh[6:0], sio_d_s};
                    end
                    if (quarter == 2'd3) begin
                        if (bit_idx != 4'd8) begin
                            bit_nx = bit_idx + 4'd1;
                            tx_nx  = {tx_sh[6:0], 1'b0};
                            if (state == S_RDATA && bit_idx == 4'd7) begin
                                rd_data_nx  = rx_sh;
                                rd_valid_nx = 1'b1;
                            end
                        end else begin
                            bit_nx = 4'd0;
                            if (CHECK_ACK && nack && state != S_RDATA) begin
                                err_nx     = 1'b1;
                                restart_nx = 1'b0;
                                state_nx   = S_STOP;
                            end else begin
                                case (state)
                                    S_ID_W: begin
                                        state_nx    = S_SUB;
                                        tx_nx       = sub_sh[SW-1 -: 8];
                                        sub_sh_nx   = sub_sh << 8;
                                        sub_left_nx = 2'(SUB_ADDR_BYTES - 1);
                                    end
                                    S_SUB: begin
                                        if (sub_left != 2'd0) begin
                                            tx_nx       = sub_sh[SW-1 -: 8];
                                            sub_sh_nx   = sub_sh << 8;
                                            sub_left_nx = sub_left - 2'd1;
                                        end else if (rw_q) begin
                                            state_nx   = S_STOP;
                                            restart_nx = 1'b1;
                                        end else if (len_left == '0) begin
                                            state_nx = S_STOP;
                                        end else begin
                                            state_nx  = S_WDATA;
                                            tx_nx     = bus.i_wdata;
                                            wr_req_nx = 1'b1;
                                        end
                                    end
                                    S_WDATA, S_RDATA: begin
                                        len_nx = len_left - LEN_W'(1);
                                        if (len_left > LEN_W'(1)) begin
                                            if (state == S_WDATA) begin
                                                tx_nx     = bus.i_wdata;
                                                wr_req_nx = 1'b1;
                                            end
                                        end else begin
                                            state_nx = S_STOP;
                                        end
                                    end
                                    S_ID_R: state_nx = S_RDATA;
                                    default: state_nx = S_STOP;
                                endcase
                            end
                        end
                    end
                end
            end
        endcase
    end

    // pad levels are decoded straight from registered state so reset releases the bus at once
    always_comb begin
        pad_c  = 1'b1;
        pad_d  = 1'b1;
        pad_oe = 1'b0;
        pad_e  = 1'b1;
        case (state)
            S_IDLE: ;
            S_START: begin
                pad_e  = 1'b0;
                pad_oe = 1'b1;
                pad_d  = (quarter == 2'd0);
                pad_c  = (quarter != 2'd3);
            end
            S_STOP: begin
                pad_e  = (quarter == 2'd3);
                pad_oe = (quarter != 2'd3);
                pad_d  = quarter[1];
                pad_c  = (quarter != 2'd0);
            end
            default: begin
                pad_e = 1'b0;
                pad_c = quarter[1];
                if (bit_idx == 4'd8) begin
                    pad_oe = (state == S_RDATA);
                    pad_d  = (state == S_RDATA) ? (len_left == LEN_W'(1)) : 1'b1;
                end else begin
                    pad_oe = (state != S_RDATA);
                    pad_d  = (state != S_RDATA) ? tx_sh[7] : 1'b1;
                end
            end
        endcase
    end

    assign bus.o_cmd_ready = (state == S_IDLE);
    assign bus.o_busy      = (state != S_IDLE);
    assign bus.o_done      = done_q;
    assign bus.o_ack_err   = err;
    assign bus.o_wr_req    = wr_req_q;
    assign bus.o_rd_valid  = rd_valid_q;
    assign bus.o_rd_data   = rd_data;
    assign bus.o_sio_c     = pad_c;
    assign bus.o_sio_d_out = pad_d;
    assign bus.o_sio_d_oe  = pad_oe;
    assign bus.o_sccb_e    = pad_e;
endmodule

// File: tb/tb_sccb_master_engine.sv
// Bench for sccb_master_engine: behavioural SCCB slave decodes the wire into a
// scoreboard of expected bytes; command results are checked at o_done.
module tb_sccb_master_engine;
    localparam int SYS  = 1_600_000;
    localparam int SCK  = 100_000;
    localparam int QDIV = 4;
    localparam int SAB  = 2;
    localparam int LW   = 4;

    typedef struct {
        logic [7:0] b;
        logic [1:0] ninth;   // 0 released, 1 master drives 0, 2 master drives 1
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sccb_master_engine_if #(.SUB_ADDR_BYTES(SAB), .LEN_W(LW)) bus();

    sccb_master_engine #(
        .SYS_CLK_FREQ(SYS), .SCCB_CLK_FREQ(SCK), .SUB_ADDR_BYTES(SAB),
        .LEN_W(LW), .CHECK_ACK(1'b1)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    int exp_lat, exp_wire, exp_wr, exp_rd, exp_erise;
    int wr_cnt, rd_cnt, wire_cnt, e_rise, widx, accept_cnt;
    logic [7:0] wq[$];
    exp_t exp_q[$];
    logic [7:0] exp_rd_q[$];

    logic slave_drv = 1'b1;
    logic ack_en = 1'b1;
    logic [7:0] rd_val = 8'h76;
    int rd_count = 0;
    int bitcnt = 0;
    int bytecnt = 0;
    logic rd_phase = 1'b0;
    logic [7:0] sh = 8'h00;
    wire line = bus.o_sio_d_oe ? bus.o_sio_d_out : slave_drv;
    assign bus.i_sio_d = line;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc++;
    always @(negedge clk) if (bus.i_cmd_valid && bus.o_cmd_ready) accept_cnt++;
    always @(posedge bus.o_sccb_e) e_rise++;

    always @(posedge clk) begin
        #1;
        if (bus.o_wr_req) begin
            wr_cnt++;
            widx++;
            if (widx < wq.size()) bus.i_wdata = wq[widx];
        end
        if (bus.o_rd_valid) begin
            rd_cnt++;
            if (exp_rd_q.size() > 0) chk("rd_data", 32'(bus.o_rd_data), 32'(exp_rd_q.pop_front()));
        end
    end

    // slave: START resets the byte decoder
    always @(negedge line) begin
        if (bus.o_sio_c && !bus.o_sccb_e) begin
            bitcnt = 0;
            bytecnt = 0;
            rd_phase = 1'b0;
        end
    end

    always @(posedge bus.o_sio_c) begin
        if (!bus.o_sccb_e) begin
            if (bitcnt < 8) begin
                sh = {sh[6:0], line};
                bitcnt++;
            end else begin
                exp_t e;
                wire_cnt++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wire_byte", 32'(sh), 32'(e.b));
                    chk("ninth_oe", 32'(bus.o_sio_d_oe), 32'(e.ninth != 2'd0));
                    if (e.ninth != 2'd0) chk("ninth_val", 32'(line), 32'(e.ninth == 2'd2));
                end
                if (bytecnt == 0 && sh[0]) rd_phase = 1'b1;
                bytecnt++;
                bitcnt = 0;
            end
        end
    end

    always @(negedge bus.o_sio_c) begin
        if (!bus.o_sccb_e) begin
            slave_drv = 1'b1;
            if (bitcnt == 8 && ack_en && !(rd_phase && bytecnt > 0)) slave_drv = 1'b0;
            if (rd_phase && bytecnt > 0 && bytecnt <= rd_count && bitcnt < 8)
                slave_drv = rd_val[3'(7 - bitcnt)];
        end
    end

    task automatic start_cmd(input logic rw, input logic [15:0] sub, input int len,
                             input logic ack_ok, input logic hold);
        int n;
        exp_q.delete();
        exp_rd_q.delete();
        exp_q.push_back('{8'h42, 2'd0});
        exp_wr = 0;
        exp_rd = 0;
        exp_erise = 1;
        rd_count = 0;
        if (!ack_ok) begin
            exp_lat = 44 * QDIV;
        end else begin
            exp_q.push_back('{sub[15:8], 2'd0});
            exp_q.push_back('{sub[7:0], 2'd0});
            if (!rw) begin
                for (int i = 0; i < len; i++) exp_q.push_back('{wq[i], 2'd0});
                exp_wr = len;
                exp_lat = (8 + 36 * (3 + len)) * QDIV;
            end else begin
                n = (len == 0) ? 1 : len;
                exp_q.push_back('{8'h43, 2'd0});
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back('{rd_val, (i == n - 1) ? 2'd2 : 2'd1});
                    exp_rd_q.push_back(rd_val);
                end
                rd_count = n;
                exp_rd = n;
                exp_erise = 2;
                exp_lat = (8 + 36 * 3 + 8 + 36 * (1 + n)) * QDIV;
            end
        end
        exp_wire = exp_q.size();
        wr_cnt = 0; rd_cnt = 0; wire_cnt = 0; e_rise = 0; widx = 0; accept_cnt = 0;
        bus.i_wdata = (wq.size() > 0) ? wq[0] : 8'h00;
        bus.i_cmd_rw = rw;
        bus.i_dev_addr = 7'h21;
        bus.i_sub_addr = sub;
        bus.i_len = LW'(len);
        bus.i_cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (bus.o_busy) break;
        end
        chk("accept", 32'(bus.o_busy), 32'd1);
        t0 = cyc;
        if (!hold) bus.i_cmd_valid = 1'b0;
        // later field changes must not affect the latched command
        bus.i_sub_addr = ~sub;
        bus.i_dev_addr = 7'h55;
        bus.i_cmd_rw = ~rw;
        bus.i_len = ~LW'(len);
    endtask

    task automatic finish_cmd(input logic exp_err);
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (bus.o_done) break;
        end
        bus.i_cmd_valid = 1'b0;
        chk("done", 32'(bus.o_done), 32'd1);
        chk("latency", 32'(cyc - t0), 32'(exp_lat));
        chk("ack_err", 32'(bus.o_ack_err), 32'(exp_err));
        chk("wr_req_cnt", 32'(wr_cnt), 32'(exp_wr));
        chk("rd_valid_cnt", 32'(rd_cnt), 32'(exp_rd));
        chk("wire_bytes", 32'(wire_cnt), 32'(exp_wire));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("sccb_e_rises", 32'(e_rise), 32'(exp_erise));
        chk("ready_after", 32'(bus.o_cmd_ready), 32'd1);
        @(posedge clk); #1;
        chk("done_pulse", 32'(bus.o_done), 32'd0);
    endtask

    initial begin
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_rw = 1'b0;
        bus.i_dev_addr = 7'h00;
        bus.i_sub_addr = '0;
        bus.i_len = '0;
        bus.i_wdata = 8'h00;
        #12;
        chk("rst_ready", 32'(bus.o_cmd_ready), 32'd1);
        chk("rst_sio_c", 32'(bus.o_sio_c), 32'd1);
        chk("rst_sio_d", 32'(bus.o_sio_d_out), 32'd1);
        chk("rst_oe", 32'(bus.o_sio_d_oe), 32'd0);
        chk("rst_sccb_e", 32'(bus.o_sccb_e), 32'd1);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_ack_err", 32'(bus.o_ack_err), 32'd0);
        chk("rst_wr_req", 32'(bus.o_wr_req), 32'd0);
        chk("rst_rd_valid", 32'(bus.o_rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.o_rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        wq = '{8'h80};
        start_cmd(1'b0, 16'h0012, 1, 1'b1, 1'b0);
        finish_cmd(1'b0);

        wq.delete();
        start_cmd(1'b1, 16'h000A, 1, 1'b1, 1'b0);
        finish_cmd(1'b0);

        wq = '{8'h11, 8'h22, 8'h33};
        start_cmd(1'b0, 16'h3018, 3, 1'b1, 1'b0);
        finish_cmd(1'b0);

        wq.delete();
        start_cmd(1'b0, 16'h3018, 0, 1'b1, 1'b0);
        finish_cmd(1'b0);

        ack_en = 1'b0;
        wq = '{8'h80};
        start_cmd(1'b0, 16'h0012, 1, 1'b0, 1'b0);
        finish_cmd(1'b1);
        ack_en = 1'b1;
        start_cmd(1'b0, 16'h0012, 1, 1'b1, 1'b0);
        finish_cmd(1'b0);

        // reset in the middle of the first sub-address byte
        wq = '{8'h5A};
        start_cmd(1'b0, 16'h3018, 1, 1'b1, 1'b0);
        repeat ((4 + 36 + 18) * QDIV) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_oe", 32'(bus.o_sio_d_oe), 32'd0);
        chk("mid_rst_sccb_e", 32'(bus.o_sccb_e), 32'd1);
        chk("mid_rst_sio_c", 32'(bus.o_sio_c), 32'd1);
        chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        exp_q.delete();
        exp_rd_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(bus.o_cmd_ready), 32'd1);

        // command valid held high through the whole transaction
        wq = '{8'hC3};
        start_cmd(1'b0, 16'h1234, 1, 1'b1, 1'b1);
        finish_cmd(1'b0);
        chk("single_accept", 32'(accept_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
